// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Commits register-file writes, holds a minimal CP0
// (BadVAddr, Count, Compare, Status, Cause, EPC), resolves exceptions, ERET and
// TLB refetch, and drives the flush/redirect and debug trace ports.
// Optional timer (Count/Compare/Cause.TI) enabled by defining CP0_TIMER_EN.
module wb_stage #(
    parameter logic [31:0] EX_VEC     = 32'hBFC00380,
    parameter logic [31:0] REFILL_VEC = 32'hBFC00200
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_to_ws_valid,
    input  logic [120:0] ms_to_ws_bus,
    output logic         ws_allowin,
    output logic [37:0]  ws_to_rf_bus,
    output logic         ws_flush,
    output logic [31:0]  ws_flush_pc,
    output logic         ws_int_pending,
    input  logic [5:0]   ext_int_in,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_wen,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata
);

    localparam logic [4:0] C0_BADVADDR = 5'd8;
    localparam logic [4:0] C0_COUNT    = 5'd9;
    localparam logic [4:0] C0_COMPARE  = 5'd11;
    localparam logic [4:0] C0_STATUS   = 5'd12;
    localparam logic [4:0] C0_CAUSE    = 5'd13;
    localparam logic [4:0] C0_EPC      = 5'd14;

    logic         r_valid;
    logic [120:0] r_bus;

    logic [31:0]  r_badvaddr;
    logic [7:0]   r_status_im;
    logic         r_status_exl;
    logic         r_status_ie;
    logic         r_cause_bd;
    logic [5:0]   r_cause_ip_hw;
    logic [1:0]   r_cause_ip_sw;
    logic [4:0]   r_cause_exccode;
    logic [31:0]  r_epc;

    logic [31:0]  w_count;
    logic [31:0]  w_compare;
    logic         w_ti;

    // Bus field decode (tlbr/tlbwi are trace-only and unused here)
    logic         w_tlb_ref, w_tlb_flush, w_bd, w_ex, w_eret, w_mfc0, w_mtc0, w_gr_we;
    logic [4:0]   w_excode, w_c0_addr, w_dest;
    logic [31:0]  w_badvaddr, w_result, w_pc;
    logic [1:0]   w_unused_trace;

    assign w_tlb_ref      = r_bus[120];
    assign w_tlb_flush    = r_bus[119];
    assign w_unused_trace = r_bus[118:117];
    assign w_bd           = r_bus[116];
    assign w_ex           = r_bus[115];
    assign w_eret         = r_bus[114];
    assign w_mfc0         = r_bus[113];
    assign w_mtc0         = r_bus[112];
    assign w_excode       = r_bus[111:107];
    assign w_badvaddr     = r_bus[106:75];
    assign w_c0_addr      = r_bus[74:70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_result       = r_bus[63:32];
    assign w_pc           = r_bus[31:0];

    logic w_exc_commit, w_eret_commit, w_mtc0_commit;
    logic w_wr_status, w_wr_cause, w_wr_epc, w_wr_count, w_wr_compare;

    assign w_exc_commit  = r_valid & w_ex;
    assign w_eret_commit = r_valid & w_eret & ~w_ex;
    assign w_mtc0_commit = r_valid & w_mtc0 & ~w_ex;
    assign w_wr_status   = w_mtc0_commit & (w_c0_addr == C0_STATUS);
    assign w_wr_cause    = w_mtc0_commit & (w_c0_addr == C0_CAUSE);
    assign w_wr_epc      = w_mtc0_commit & (w_c0_addr == C0_EPC);
    assign w_wr_count    = w_mtc0_commit & (w_c0_addr == C0_COUNT);
    assign w_wr_compare  = w_mtc0_commit & (w_c0_addr == C0_COMPARE);

    logic [31:0] w_status, w_cause;
    assign w_status = {9'b0, 1'b1, 6'b0, r_status_im, 6'b0, r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, w_ti, 14'b0, r_cause_ip_hw, r_cause_ip_sw,
                       1'b0, r_cause_exccode, 2'b0};

    logic w_badv_exc;
    assign w_badv_exc = (w_excode >= 5'd1) && (w_excode <= 5'd5);

    // Pipeline register: flush squashes whatever arrives behind the flushing instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else begin
            r_valid <= ws_flush ? 1'b0 : ms_to_ws_valid;
            if (ms_to_ws_valid && ws_allowin)
                r_bus <= ms_to_ws_bus;
        end
    end

    // CP0 Status/Cause/EPC/BadVAddr update; exception beats ERET beats mtc0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_badvaddr      <= '0;
            r_status_im     <= '0;
            r_status_exl    <= 1'b0;
            r_status_ie     <= 1'b0;
            r_cause_bd      <= 1'b0;
            r_cause_ip_hw   <= '0;
            r_cause_ip_sw   <= '0;
            r_cause_exccode <= '0;
            r_epc           <= '0;
        end else begin
            r_cause_ip_hw <= {ext_int_in[5] | w_ti, ext_int_in[4:0]};
            if (w_exc_commit) begin
                if (!r_status_exl) begin
                    r_epc      <= w_bd ? w_pc - 32'd4 : w_pc;
                    r_cause_bd <= w_bd;
                end
                r_status_exl    <= 1'b1;
                r_cause_exccode <= w_excode;
                if (w_badv_exc)
                    r_badvaddr <= w_badvaddr;
            end else if (w_eret_commit) begin
                r_status_exl <= 1'b0;
            end else begin
                if (w_wr_status) begin
                    r_status_im  <= w_result[15:8];
                    r_status_exl <= w_result[1];
                    r_status_ie  <= w_result[0];
                end
                if (w_wr_cause)
                    r_cause_ip_sw <= w_result[9:8];
                if (w_wr_epc)
                    r_epc <= w_result;
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Timer: Count advances every other cycle; Count==Compare raises TI, Compare write clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick    <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count)
                r_count <= w_result;
            else if (r_tick)
                r_count <= r_count + 32'd1;
            if (w_wr_compare) begin
                r_compare <= w_result;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_count   = r_count;
    assign w_compare = r_compare;
    assign w_ti      = r_ti;
`else
    logic w_unused_timer_wr;
    assign w_unused_timer_wr = w_wr_count | w_wr_compare;
    assign w_count   = '0;
    assign w_compare = '0;
    assign w_ti      = 1'b0;
`endif

    // CP0 read mux for mfc0
    logic [31:0] w_cp0_rdata;
    always_comb begin
        w_cp0_rdata = '0;
        case (w_c0_addr)
            C0_BADVADDR: w_cp0_rdata = r_badvaddr;
            C0_COUNT:    w_cp0_rdata = w_count;
            C0_COMPARE:  w_cp0_rdata = w_compare;
            C0_STATUS:   w_cp0_rdata = w_status;
            C0_CAUSE:    w_cp0_rdata = w_cause;
            C0_EPC:      w_cp0_rdata = r_epc;
            default:     w_cp0_rdata = '0;
        endcase
    end

    // Redirect target in priority order: refill, general exception, ERET, refetch
    always_comb begin
        ws_flush_pc = '0;
        if (w_ex && w_tlb_ref && !r_status_exl)
            ws_flush_pc = REFILL_VEC;
        else if (w_ex)
            ws_flush_pc = EX_VEC;
        else if (w_eret)
            ws_flush_pc = r_epc;
        else if (w_tlb_flush)
            ws_flush_pc = w_pc + 32'd4;
        if (!ws_flush)
            ws_flush_pc = '0;
    end

    logic        w_rf_we;
    logic [31:0] w_rf_wdata;
    assign w_rf_we    = r_valid & w_gr_we & ~w_ex;
    assign w_rf_wdata = w_mfc0 ? w_cp0_rdata : w_result;

    assign ws_allowin        = 1'b1;
    assign ws_flush          = r_valid & (w_ex | w_eret | w_tlb_flush);
    assign ws_to_rf_bus      = {w_rf_we, w_dest, w_rf_wdata};
    assign ws_int_pending    = r_status_ie & ~r_status_exl &
                               (|({r_cause_ip_hw, r_cause_ip_sw} & r_status_im));
    assign debug_wb_pc       = w_pc;
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = w_dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

endmodule
